code_lock_controller: RTL and testbench
=======================================

# code_lock_controller

Sequencing controller for the keypad code-entry path. Accepts debounced single-cycle digit strobes, tracks digit position, compares the completed entry against a stored code, and drives unlock, failure and lockout status. Sits between the keypad front end and the door/indicator outputs. It also owns the stored code and reprogramming of it.

## Interface
- N_DIGITS, 4, digits per code (≥2)
- DIGIT_W, 4, bits per digit
- DEFAULT_CODE, 16'h1234, code loaded at reset; first digit in MSBs, width N_DIGITS*DIGIT_W
- MAX_FAILS, 3, consecutive mismatches that trigger lockout (≥1)
- UNLOCK_CYCLES, 50_000_000, cycles unlocked_o stays high (≥1)
- LOCKOUT_CYCLES, 500_000_000, cycles lockout_o stays high (≥1)

- clk_i  in  1  single clock
- rst_ni  in  1  asynchronous, active-low reset
- entry_i  in  1  one-cycle digit strobe, already synchronised and debounced
- digit_i  in  DIGIT_W  digit value, valid when entry_i=1
- clear_i  in  1  abort current entry (count to 0)
- program_i  in  1  level; while unlocked, digit entries form a new code
- entering_last_digit_o  out  1  next accepted digit completes the code
- digit_count_o  out  $clog2(N_DIGITS)  digits accepted in current entry
- unlocked_o  out  1  code matched, unlock window active
- fail_o  out  1  one-cycle pulse per mismatch
- lockout_o  out  1  lockout window active, entries ignored
- code_stored_o  out  1  one-cycle pulse when a new code is written

## Operation
- States: ENTER, CHECK, UNLOCKED, LOCKOUT. Reset: ENTER, code_reg=DEFAULT_CODE, count=0, fail_cnt=0, timer=0, every output 0. Reset mid-operation discards a programmed code.
- ENTER: entry_i shifts digit_i into entry_reg (left shift, first digit ends in MSBs), count+1. Strobe with count==N_DIGITS-1 → CHECK, count←0.
- CHECK (exactly 1 cycle, entry_i ignored): entry_reg==code_reg → UNLOCKED, fail_cnt←0, timer←UNLOCK_CYCLES-1. Mismatch → fail_o pulse; if fail_cnt==MAX_FAILS-1 → LOCKOUT, fail_cnt←0, timer←LOCKOUT_CYCLES-1; else fail_cnt+1, → ENTER.
- UNLOCKED: unlocked_o=1. entry_i with program_i=0 ignored. entry_i with program_i=1 accepted as in ENTER and reloads timer to UNLOCK_CYCLES-1. N-th programming digit: code_reg←new code, code_stored_o pulse, → ENTER. Timer==0 with no strobe that cycle → ENTER, count←0 (partial programming discarded).
- LOCKOUT: lockout_o=1, entry_i/clear_i ignored; timer==0 → ENTER.
- clear_i: in ENTER, or in UNLOCKED while programming, count←0; priority over entry_i in the same cycle; fail_cnt unchanged.
- entering_last_digit_o = (ENTER, or UNLOCKED with program_i=1) and count==N_DIGITS-1.

## Timing
- All outputs are functions of registers only; no combinational input-to-output path.
- Digit strobe sampled at edge k → digit_count_o/entering_last_digit_o update after edge k.
- Last digit at edge k → CHECK after k; unlocked_o, or fail_o/lockout_o, asserted after edge k+1.
- unlocked_o high exactly UNLOCK_CYCLES cycles absent programming strobes; lockout_o exactly LOCKOUT_CYCLES cycles.
- fail_o and code_stored_o are exactly one cycle wide.
- Strobes on consecutive cycles are each accepted, except a strobe landing in CHECK, which is dropped.
- Timer width $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)); count wraps only via CHECK/store, never by overflow.

## Structure
- Package code_lock_pkg: state enum typedef, DEFAULT_CODE and bench-size parameter constants.
- Sub-module cycle_timer: loadable down-counter with zero flag, shared by UNLOCKED and LOCKOUT.
- FSM, entry shift register, code register, fail counter in code_lock_controller.

## Test plan
Params N_DIGITS=4, DEFAULT_CODE=16'h1234, MAX_FAILS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16.
- Strobe 1,2,3 → entering_last_digit_o=1 after the third strobe; digit 4 → unlocked_o=1 two edges later, held 8 cycles, then 0.
- Enter 1,2,3,5 → fail_o one-cycle pulse, unlocked_o stays 0, digit_count_o=0.
- Three wrong codes → third raises lockout_o for 16 cycles; correct code during lockout ignored; correct code afterwards unlocks.
- Unlock, program_i=1, enter 9,8,7,6 → code_stored_o pulse, return to ENTER; 1,2,3,4 fails, 9,8,7,6 unlocks.
- Enter 1,2, assert clear_i with entry_i → count=0, digit dropped; then 1,2,3,4 unlocks.
- Two failures, then rst_ni low mid-entry → all outputs 0, code back to 16'h1234, fail count cleared (three more failures needed for lockout).

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared types and constants for the keypad code-lock controller.
package code_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTER,
    ST_CHECK,
    ST_UNLOCKED,
    ST_LOCKOUT
  } lock_state_e;

  localparam logic [15:0] DEFAULT_CODE = 16'h1234;

  localparam int TB_N_DIGITS       = 4;
  localparam int TB_DIGIT_W        = 4;
  localparam int TB_MAX_FAILS      = 3;
  localparam int TB_UNLOCK_CYCLES  = 8;
  localparam int TB_LOCKOUT_CYCLES = 16;

  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/code_lock_if.sv
// Keypad-side and status-side signals of the code-lock controller.
interface code_lock_if #(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4
);
  localparam int CNT_W = (N_DIGITS < 2) ? 1 : $clog2(N_DIGITS);

  logic               entry_i;
  logic [DIGIT_W-1:0] digit_i;
  logic               clear_i;
  logic               program_i;
  logic               entering_last_digit_o;
  logic [CNT_W-1:0]   digit_count_o;
  logic               unlocked_o;
  logic               fail_o;
  logic               lockout_o;
  logic               code_stored_o;

  modport master (
    output entry_i, digit_i, clear_i, program_i,
    input  entering_last_digit_o, digit_count_o, unlocked_o,
           fail_o, lockout_o, code_stored_o
  );

  modport slave (
    input  entry_i, digit_i, clear_i, program_i,
    output entering_last_digit_o, digit_count_o, unlocked_o,
           fail_o, lockout_o, code_stored_o
  );
endinterface

// File: rtl/code_lock_controller_cycle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/code_lock_controller.sv
// Code-entry sequencer: collects digits, compares against the stored code,
// drives unlock/fail/lockout status and handles reprogramming while unlocked.
module code_lock_controller
  import code_lock_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = code_lock_pkg::DEFAULT_CODE,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 50_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000
) (
  input logic       clk_i,
  input logic       rst_ni,
  code_lock_if.slave bus
);

  localparam int CODE_W  = N_DIGITS * DIGIT_W;
  localparam int CNT_W   = (N_DIGITS < 2) ? 1 : $clog2(N_DIGITS);
  localparam int FAIL_W  = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS);
  localparam int TIMER_W = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

  localparam logic [CNT_W-1:0]   LAST_IDX    = CNT_W'(N_DIGITS - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LAST   = FAIL_W'(MAX_FAILS - 1);
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCKOUT_CYCLES - 1);

  lock_state_e         state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CODE_W-1:0]   entry_q, entry_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [FAIL_W-1:0]   fails_q, fails_d;
  logic                fail_q, fail_d;
  logic                stored_q, stored_d;
  logic                last_q, last_d;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_value;
  logic                timer_zero;
  logic                prog_strobe;
  logic [CODE_W-1:0]   shifted;

  cycle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (timer_load),
    .value_i (timer_value),
    .zero_o  (timer_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_ENTER;
      count_q  <= '0;
      entry_q  <= '0;
      code_q   <= DEFAULT_CODE;
      fails_q  <= '0;
      fail_q   <= 1'b0;
      stored_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      entry_q  <= entry_d;
      code_q   <= code_d;
      fails_q  <= fails_d;
      fail_q   <= fail_d;
      stored_q <= stored_d;
      last_q   <= last_d;
    end
  end

  assign shifted     = {entry_q[CODE_W-DIGIT_W-1:0], bus.digit_i};
  assign prog_strobe = bus.entry_i && bus.program_i && !bus.clear_i;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    entry_d     = entry_q;
    code_d      = code_q;
    fails_d     = fails_q;
    fail_d      = 1'b0;
    stored_d    = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;

    case (state_q)
      ST_ENTER: begin
        if (bus.clear_i) begin
          count_d = '0;
        end else if (bus.entry_i) begin
          entry_d = shifted;
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = ST_CHECK;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      ST_CHECK: begin
        if (entry_q == code_q) begin
          state_d     = ST_UNLOCKED;
          fails_d     = '0;
          timer_load  = 1'b1;
          timer_value = UNLOCK_LOAD;
        end else begin
          fail_d = 1'b1;
          if (fails_q == FAIL_LAST) begin
            state_d     = ST_LOCKOUT;
            fails_d     = '0;
            timer_load  = 1'b1;
            timer_value = LOCK_LOAD;
          end else begin
            fails_d = fails_q + FAIL_W'(1);
            state_d = ST_ENTER;
          end
        end
      end

      // Programming strobes keep the window open; an idle expiry drops any partial code.
      ST_UNLOCKED: begin
        if (bus.program_i && bus.clear_i) begin
          count_d = '0;
        end else if (prog_strobe) begin
          entry_d     = shifted;
          timer_load  = 1'b1;
          timer_value = UNLOCK_LOAD;
          if (count_q == LAST_IDX) begin
            code_d   = shifted;
            stored_d = 1'b1;
            count_d  = '0;
            state_d  = ST_ENTER;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        if (!prog_strobe && timer_zero) begin
          count_d = '0;
          state_d = ST_ENTER;
        end
      end

      ST_LOCKOUT: begin
        if (timer_zero) begin
          state_d = ST_ENTER;
        end
      end

      default: begin
        state_d = ST_ENTER;
        count_d = '0;
      end
    endcase

    last_d = ((state_d == ST_ENTER) || ((state_d == ST_UNLOCKED) && bus.program_i))
             && (count_d == LAST_IDX);
  end

  assign bus.digit_count_o         = count_q;
  assign bus.entering_last_digit_o = last_q;
  assign bus.unlocked_o            = (state_q == ST_UNLOCKED);
  assign bus.lockout_o             = (state_q == ST_LOCKOUT);
  assign bus.fail_o                = fail_q;
  assign bus.code_stored_o         = stored_q;

endmodule

// File: tb/tb_code_lock_controller.sv
// Self-checking bench: fixed vector table, directed corner sequences and a
// randomized run compared against a digit-queue reference model.
module tb_code_lock_controller;
  import code_lock_pkg::*;

  localparam int N  = TB_N_DIGITS;
  localparam int W  = TB_DIGIT_W;
  localparam int MF = TB_MAX_FAILS;
  localparam int UC = TB_UNLOCK_CYCLES;
  localparam int LC = TB_LOCKOUT_CYCLES;

  localparam logic [6:0] M_CNT  = 7'b1100000;
  localparam logic [6:0] M_LAST = 7'b0010000;
  localparam logic [6:0] M_UNL  = 7'b0001000;
  localparam logic [6:0] M_FAIL = 7'b0000100;
  localparam logic [6:0] M_LOCK = 7'b0000010;
  localparam logic [6:0] M_ST   = 7'b0000001;
  localparam logic [6:0] M_ALL  = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  code_lock_if #(.N_DIGITS(N), .DIGIT_W(W)) bus ();

  code_lock_controller #(
    .N_DIGITS       (N),
    .DIGIT_W        (W),
    .DEFAULT_CODE   (DEFAULT_CODE),
    .MAX_FAILS      (MF),
    .UNLOCK_CYCLES  (UC),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit         e;
    logic [3:0] d;
    bit         c;
    bit         p;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[$];

  // Reference model: digits typed so far, stored code and remaining window lengths.
  int typed[$];
  int code_m[N];
  int m_fails, m_unlock, m_lock;
  bit m_pending, m_fail, m_stored, m_last;

  function automatic logic [6:0] outs();
    return {bus.digit_count_o, bus.entering_last_digit_o, bus.unlocked_o,
            bus.fail_o, bus.lockout_o, bus.code_stored_o};
  endfunction

  function automatic logic [6:0] ex(int cnt, bit last, bit unl, bit fail, bit lock, bit st);
    return {2'(cnt), last, unl, fail, lock, st};
  endfunction

  function automatic void addVec(bit e, int d, bit c, bit p, logic [6:0] x);
    vec_t v;
    v.e = e; v.d = 4'(d); v.c = c; v.p = p; v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [6:0] exp, input logic [6:0] mask);
    logic [6:0] got;
    got = outs();
    checks++;
    if ((got & mask) === (exp & mask)) passes++;
    else $display("[TB] FAIL %s: got cnt/last/unl/fail/lock/st=%b required %b (mask %b)",
                  name, got, exp, mask);
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  task automatic applyStimulus(input bit e, input int d, input bit c, input bit p);
    @(negedge clk);
    bus.entry_i   = e;
    bus.digit_i   = 4'(d);
    bus.clear_i   = c;
    bus.program_i = p;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    bus.entry_i = 0; bus.digit_i = 0; bus.clear_i = 0; bus.program_i = 0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset state", 7'b0, M_ALL);
    rst_n = 1'b1;
  endtask

  task automatic enterCode(input logic [15:0] c, input bit p);
    for (int i = 0; i < N; i++) applyStimulus(1, int'(c[15-4*i -: 4]), 0, p);
  endtask

  task automatic modelReset();
    typed.delete();
    code_m[0] = 1; code_m[1] = 2; code_m[2] = 3; code_m[3] = 4;
    m_fails = 0; m_unlock = 0; m_lock = 0;
    m_pending = 0; m_fail = 0; m_stored = 0; m_last = 0;
  endtask

  task automatic modelStep(input bit e, input int d, input bit c, input bit p);
    bit match;
    m_fail = 0;
    m_stored = 0;
    if (m_pending) begin
      match = 1;
      for (int i = 0; i < N; i++) if (typed[i] != code_m[i]) match = 0;
      if (match) begin
        m_unlock = UC;
        m_fails = 0;
      end else begin
        m_fail = 1;
        m_fails++;
        if (m_fails == MF) begin
          m_lock = LC;
          m_fails = 0;
        end
      end
      typed.delete();
      m_pending = 0;
    end else if (m_lock > 0) begin
      m_lock--;
    end else if (m_unlock > 0) begin
      if (p && e && !c) begin
        typed.push_back(d);
        m_unlock = UC;
        if (typed.size() == N) begin
          for (int i = 0; i < N; i++) code_m[i] = typed[i];
          m_stored = 1;
          typed.delete();
          m_unlock = 0;
        end
      end else begin
        if (p && c) typed.delete();
        m_unlock--;
        if (m_unlock == 0) typed.delete();
      end
    end else begin
      if (c) typed.delete();
      else if (e) begin
        typed.push_back(d);
        if (typed.size() == N) m_pending = 1;
      end
    end
    m_last = !m_pending && (m_lock == 0) && (m_unlock == 0 || p) && (typed.size() == N - 1);
  endtask

  function automatic logic [6:0] modelExp();
    return ex(m_pending ? 0 : typed.size(), m_last, m_unlock > 0, m_fail, m_lock > 0, m_stored);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int k;
    bit p_r;
    bit e_r, c_r;
    int d_r;

    bus.entry_i = 0; bus.digit_i = 0; bus.clear_i = 0; bus.program_i = 0;

    // Table: unlock, ignored strobe while unlocked, mismatch, clear-with-strobe.
    addVec(1, 1, 0, 0, ex(1, 0, 0, 0, 0, 0));
    addVec(1, 2, 0, 0, ex(2, 0, 0, 0, 0, 0));
    addVec(1, 3, 0, 0, ex(3, 1, 0, 0, 0, 0));
    addVec(1, 4, 0, 0, ex(0, 0, 0, 0, 0, 0));
    addVec(0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));
    addVec(1, 9, 0, 0, ex(0, 0, 1, 0, 0, 0));
    for (int i = 0; i < UC - 2; i++) addVec(0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));
    addVec(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    addVec(1, 1, 0, 0, ex(1, 0, 0, 0, 0, 0));
    addVec(1, 2, 0, 0, ex(2, 0, 0, 0, 0, 0));
    addVec(1, 3, 0, 0, ex(3, 1, 0, 0, 0, 0));
    addVec(1, 5, 0, 0, ex(0, 0, 0, 0, 0, 0));
    addVec(0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0));
    addVec(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    addVec(1, 1, 0, 0, ex(1, 0, 0, 0, 0, 0));
    addVec(1, 2, 0, 0, ex(2, 0, 0, 0, 0, 0));
    addVec(1, 7, 1, 0, ex(0, 0, 0, 0, 0, 0));
    addVec(1, 1, 0, 0, ex(1, 0, 0, 0, 0, 0));
    addVec(1, 2, 0, 0, ex(2, 0, 0, 0, 0, 0));
    addVec(1, 3, 0, 0, ex(3, 1, 0, 0, 0, 0));
    addVec(1, 4, 0, 0, ex(0, 0, 0, 0, 0, 0));
    addVec(0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].e, int'(vecs[i].d), vecs[i].c, vecs[i].p);
      checkOutput($sformatf("vector %0d", i), vecs[i].exp, M_ALL);
    end

    // Three mismatches lock out; entries during lockout are ignored.
    doReset();
    for (int f = 0; f < MF; f++) begin
      enterCode(16'h5555, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("mismatch %0d", f), ex(0, 0, 0, 1, f == MF - 1, 0),
                  M_UNL | M_FAIL | M_LOCK | M_CNT);
    end
    n = 1;
    for (int i = 0; i < N; i++) begin
      applyStimulus(1, i + 1, (i == 1), 0);
      checkOutput("lockout ignores digit", ex(0, 0, 0, 0, 1, 0), M_CNT | M_UNL | M_LOCK);
      n++;
    end
    k = 0;
    while (bus.lockout_o === 1'b1 && k < 40) begin
      applyStimulus(0, 0, 0, 0);
      if (bus.lockout_o === 1'b1) n++;
      k++;
    end
    checkCount("lockout length", n, LC);
    enterCode(16'h1234, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("unlock after lockout", ex(0, 0, 1, 0, 0, 0), M_UNL | M_LOCK | M_FAIL);

    // Reprogram to 9876 while unlocked.
    for (int i = 0; i < N; i++) begin
      applyStimulus(1, 9 - i, 0, 1);
      if (i == N - 2)
        checkOutput("program last-digit flag", ex(3, 1, 1, 0, 0, 0), M_ALL);
    end
    checkOutput("code stored", ex(0, 0, 0, 0, 0, 1), M_ALL);
    applyStimulus(0, 0, 0, 0);
    checkOutput("store pulse width", ex(0, 0, 0, 0, 0, 0), M_ALL);
    enterCode(16'h1234, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("old code rejected", ex(0, 0, 0, 1, 0, 0), M_UNL | M_FAIL);
    enterCode(16'h9876, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("new code accepted", ex(0, 0, 1, 0, 0, 0), M_UNL | M_FAIL);

    // Reset mid-entry restores the default code and clears the fail count.
    k = 0;
    while (bus.unlocked_o === 1'b1 && k < 20) begin
      applyStimulus(0, 0, 0, 0);
      k++;
    end
    checkOutput("unlock window expires", 7'b0, M_UNL);
    for (int f = 0; f < 2; f++) begin
      enterCode(16'h5555, 0);
      applyStimulus(0, 0, 0, 0);
    end
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 2, 0, 0);
    #2;
    rst_n = 1'b0;
    bus.entry_i = 0; bus.digit_i = 0; bus.program_i = 0; bus.clear_i = 0;
    #1;
    checkOutput("async reset mid-entry", 7'b0, M_ALL);
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < MF; f++) begin
      enterCode(16'h5555, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("post-reset mismatch %0d", f), ex(0, 0, 0, 1, f == MF - 1, 0),
                  M_FAIL | M_LOCK);
    end
    k = 0;
    while (bus.lockout_o === 1'b1 && k < 30) begin
      applyStimulus(0, 0, 0, 0);
      k++;
    end
    checkOutput("lockout ends", 7'b0, M_LOCK);
    enterCode(16'h1234, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("default code restored", ex(0, 0, 1, 0, 0, 0), M_UNL | M_FAIL);

    // Randomized run against the reference model.
    doReset();
    modelReset();
    p_r = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(15) == 0) p_r = !p_r;
      e_r = ($urandom_range(2) == 0);
      c_r = ($urandom_range(39) == 0);
      if (!m_pending && typed.size() < N && $urandom_range(7) != 0)
        d_r = code_m[typed.size()];
      else
        d_r = int'($urandom_range(15));
      applyStimulus(e_r, d_r, c_r, p_r);
      modelStep(e_r, d_r, c_r, p_r);
      checkOutput($sformatf("random cycle %0d", cyc), modelExp(), M_ALL);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
